bullet_pool_ctrl: RTL
=====================

BULLET_POOL_CTRL -- requirements
Module: bullet_pool_ctrl

Interface
REQ-001 SHALL have parameters: NUM_BULLETS, default 4, number of bullet slots; SPR_W, default 7, sprite width (px); SPR_H, default 25, sprite height (px); BULLET_SPEED, default 4, upward px per frame.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
- Clk  in  1  system clock
- Reset_n  in  1  async active-low reset
- frame_clk  in  1  VGA frame strobe, synchronous to Clk
- spawn_req  in  1  request new bullet
- spawn_x, spawn_y  in  10 each  top-left of new bullet
- spawn_ack  out  1  one-cycle accept pulse
- spawn_slot  out  2  slot granted, valid with spawn_ack
- spawn_full  out  1  no free slot
- kill_req  in  1  free slot kill_slot
- kill_slot  in  2  slot to free
- DrawX, DrawY  in  10 each  current pixel
- read_address  out  19  sprite RAM read address
- data_In  in  5  sprite RAM data; only [2:0] used
- pix_valid  out  1  opaque bullet texel at pixel
- pix_index  out  3  palette index
- active_mask  out  NUM_BULLETS  slot-occupied flags

Function
REQ-003 Each slot SHALL hold active bit, X[9:0], Y[9:0].
REQ-004 Spawn: the request is accepted when spawn_req=1, spawn_ack=0 and a free slot exists. The lowest-index free slot SHALL be loaded with spawn_x/spawn_y and made active at that edge. spawn_ack=1 and spawn_slot SHALL be registered for exactly one cycle.
REQ-005 When spawn_req is still high during the spawn_ack cycle, it SHALL NOT cause a second spawn.
REQ-006 spawn_full SHALL equal AND of active_mask (combinational). With all slots full, spawn_req SHALL be held off with no ack and no state change.
REQ-007 Kill: kill_req=1 SHALL clear active[kill_slot] at the edge. Killing an inactive slot SHALL have no effect.
REQ-008 Same-cycle kill and spawn: the spawn SHALL select a free slot from the pre-kill mask. The killed slot SHALL NOT be reused in that cycle.
REQ-009 A frame tick is the cycle after frame_clk is sampled 0 then 1 (one registered edge detector).
REQ-010 On a tick, each active slot SHALL do Y <= Y - BULLET_SPEED. A slot with Y < BULLET_SPEED SHALL instead become inactive.
REQ-011 Tick coincident with spawn: the new bullet SHALL load unmoved. Tick coincident with kill: kill wins.
REQ-012 Hit test for slot i SHALL be active && X <= DrawX < X+SPR_W && Y <= DrawY < Y+SPR_H. Sums SHALL use 11-bit arithmetic so there is no wrap at the screen edge.
REQ-013 Arbitration SHALL select the lowest-index hitting slot. Only one RAM read SHALL be issued per pixel; lower slots fully occlude higher ones.
REQ-014 Pipeline:
- edge 1: read_address <= (DrawY-Y)*SPR_W + (DrawX-X) of the winner, else 0; hit_d1 registered.
- edge 2: RAM returns data_In; hit_d2.
- edge 3: pix_index <= data_In[2:0], pix_valid <= hit_d2 && data_In[2:0]!=0.
- Total latency DrawX/DrawY -> pix outputs SHALL be 3 cycles, fully pipelined, one pixel per cycle.
REQ-015 Index 0 SHALL be transparent: pix_valid=0, pix_index passes the raw value.
REQ-016 Slot updates mid-pipeline SHALL affect only pixels sampled after the update edge.

Reset
REQ-017 Reset_n=0 SHALL asynchronously clear all slot fields, active_mask, spawn_ack, spawn_slot, read_address, the pipeline valids, pix_valid, pix_index and the frame_clk edge register to 0.
REQ-018 Reset mid-spawn SHALL leave no slot active and no pending ack after release.
REQ-019 The first frame_clk high after release SHALL count as a tick only if frame_clk was sampled 0 first.

Structure
REQ-020 Shared package SHALL define SPR_W, SPR_H, SCREEN_W=640, SCREEN_H=480, BULLET_SPEED and a bullet_slot_t struct (active, x, y).
REQ-021 One sub-module SHALL be used: bullet_hit_arb (combinational hit test + priority encode + address compute).

Verification
REQ-022 Spawn (100,200) from empty -> spawn_slot=0, one-cycle ack, active_mask=0001. Second spawn -> slot 1.
REQ-023 Four spawns, then fifth req held 10 cycles -> spawn_full=1, no ack. kill_slot=2 -> next spawn gets slot 2.
REQ-024 Slot 0 at Y=6, BULLET_SPEED=4, two ticks -> Y=2, then inactive.
REQ-025 Slots 0 and 1 both at (50,50); DrawX=53, DrawY=60 -> read_address=73 one cycle later. RAM value 5 -> pix_valid=1, pix_index=5 at cycle 3. RAM value 0 -> pix_valid=0.
REQ-026 Same-cycle kill slot 0 + spawn with mask 1111 -> no ack. Same-cycle tick + spawn -> new Y unmoved.
REQ-027 Reset_n pulsed mid-pipeline -> all outputs 0 asynchronously, active_mask=0.

Source files
------------

// File: rtl/bullet_pool_pkg.sv
// Shared constants and slot record for the bullet pool.
//   SPR_W/SPR_H   : bullet sprite size in pixels
//   SCREEN_W/H    : visible raster size
//   BULLET_SPEED  : upward pixels per frame tick
//   bullet_slot_t : one pool entry (active flag, top-left X/Y)
package bullet_pool_pkg;

  localparam int SPR_W        = 7;
  localparam int SPR_H        = 25;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BULLET_SPEED = 4;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } bullet_slot_t;

endpackage

// File: rtl/bullet_hit_arb.sv
// Combinational hit test, priority select and sprite address for one pixel.
//   slots  : all pool entries
//   draw_x : current pixel X
//   draw_y : current pixel Y
//   hit    : some active bullet covers the pixel
//   addr   : texel address (row*SPR_W + col) inside the winning sprite, 0 if no hit
module bullet_hit_arb #(
  parameter int NUM_BULLETS = 4,
  parameter int SPR_W       = 7,
  parameter int SPR_H       = 25
) (
  input  bullet_pool_pkg::bullet_slot_t [NUM_BULLETS-1:0] slots,
  input  logic [9:0]                                      draw_x,
  input  logic [9:0]                                      draw_y,
  output logic                                            hit,
  output logic [18:0]                                     addr
);
  import bullet_pool_pkg::*;

  logic [NUM_BULLETS-1:0] hit_vec;
  logic [9:0]             win_x, win_y, off_x, off_y;

  // 11-bit compares so X+SPR_W / Y+SPR_H never wrap near the screen edge.
  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_hit
    assign hit_vec[g] = slots[g].active &&
      ({1'b0, draw_x} >= {1'b0, slots[g].x}) &&
      ({1'b0, draw_x} <  ({1'b0, slots[g].x} + 11'(SPR_W))) &&
      ({1'b0, draw_y} >= {1'b0, slots[g].y}) &&
      ({1'b0, draw_y} <  ({1'b0, slots[g].y} + 11'(SPR_H)));
  end

  // Scan high to low so the lowest hitting index is the last write and wins.
  always_comb begin
    hit   = 1'b0;
    win_x = '0;
    win_y = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit   = 1'b1;
        win_x = slots[i].x;
        win_y = slots[i].y;
      end
    end
  end

  // Offsets are non-negative whenever hit is set; otherwise addr is forced to 0.
  assign off_x = draw_x - win_x;
  assign off_y = draw_y - win_y;
  assign addr  = hit ? ({9'b0, off_y} * 19'(SPR_W) + {9'b0, off_x}) : '0;

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet pool: NUM_BULLETS slots with spawn/kill, per-frame upward motion and
// a 3-cycle pixel pipeline that reads the bullet sprite from external RAM.
//   Clk, Reset_n            : clock, async active-low reset
//   frame_clk               : frame strobe (sync to Clk), rising edge -> tick
//   spawn_req/x/y           : spawn request and top-left position
//   spawn_ack/slot/full     : one-cycle accept pulse, granted slot, pool full
//   kill_req/kill_slot      : free a slot
//   DrawX, DrawY            : current pixel
//   read_address, data_In   : sprite RAM port (1-cycle read latency)
//   pix_valid, pix_index    : opaque-texel flag and palette index, 3 cycles after DrawX/Y
//   active_mask             : per-slot occupied flags
module bullet_pool_ctrl #(
  parameter  int NUM_BULLETS  = 4,
  parameter  int SPR_W        = bullet_pool_pkg::SPR_W,
  parameter  int SPR_H        = bullet_pool_pkg::SPR_H,
  parameter  int BULLET_SPEED = bullet_pool_pkg::BULLET_SPEED,
  localparam int SLOT_W       = $clog2(NUM_BULLETS)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   spawn_req,
  input  logic [9:0]             spawn_x,
  input  logic [9:0]             spawn_y,
  output logic                   spawn_ack,
  output logic [SLOT_W-1:0]      spawn_slot,
  output logic                   spawn_full,
  input  logic                   kill_req,
  input  logic [SLOT_W-1:0]      kill_slot,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic [18:0]            read_address,
  input  logic [4:0]             data_In,
  output logic                   pix_valid,
  output logic [2:0]             pix_index,
  output logic [NUM_BULLETS-1:0] active_mask
);
  import bullet_pool_pkg::*;

  localparam int STAGES = 1;  // vld_pipe[0] = hit_d1, vld_pipe[1] = hit_d2

  bullet_slot_t [NUM_BULLETS-1:0] slots;
  logic [NUM_BULLETS-1:0]         act_vec;
  logic                           have_free, spawn_go;
  logic [SLOT_W-1:0]              spawn_sel;
  logic                           frame_lo, tick_q;
  logic                           hit;
  logic [18:0]                    hit_addr;
  logic [STAGES:0]                vld_pipe;
  logic                           unused_data;

  assign unused_data = ^data_In[4:3];

  always_comb begin
    act_vec = '0;
    for (int i = 0; i < NUM_BULLETS; i++) act_vec[i] = slots[i].active;
  end

  assign active_mask = act_vec;
  assign spawn_full  = &act_vec;

  // Lowest free slot from the pre-kill mask, so a slot freed this cycle is not reused.
  always_comb begin
    have_free = 1'b0;
    spawn_sel = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!act_vec[i]) begin
        have_free = 1'b1;
        spawn_sel = SLOT_W'(i);
      end
    end
  end

  // Gating on spawn_ack keeps a held request from spawning twice.
  assign spawn_go = spawn_req && !spawn_ack && have_free;

  // frame_lo records "last sample was 0"; it resets to 0 so a strobe already
  // high at reset release is not mistaken for a rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_lo <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      frame_lo <= !frame_clk;
      tick_q   <= frame_clk && frame_lo;
    end
  end

  // Per-slot priority: spawn load (unmoved) > kill > tick motion/expiry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slots <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (spawn_go && spawn_sel == SLOT_W'(i)) begin
          slots[i].active <= 1'b1;
          slots[i].x      <= spawn_x;
          slots[i].y      <= spawn_y;
        end else if (kill_req && kill_slot == SLOT_W'(i)) begin
          slots[i].active <= 1'b0;
        end else if (tick_q && slots[i].active) begin
          if (slots[i].y < 10'(BULLET_SPEED)) slots[i].active <= 1'b0;
          else                                slots[i].y      <= slots[i].y - 10'(BULLET_SPEED);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_ack  <= 1'b0;
      spawn_slot <= '0;
    end else begin
      spawn_ack  <= spawn_go;
      spawn_slot <= spawn_go ? spawn_sel : '0;
    end
  end

  bullet_hit_arb #(
    .NUM_BULLETS(NUM_BULLETS),
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H)
  ) u_arb (
    .slots (slots),
    .draw_x(DrawX),
    .draw_y(DrawY),
    .hit   (hit),
    .addr  (hit_addr)
  );

  // edge1: address + hit_d1; edge2: RAM data arrives, hit_d2; edge3: pixel out.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      vld_pipe     <= '0;
      pix_valid    <= 1'b0;
      pix_index    <= '0;
    end else begin
      read_address <= hit_addr;
      vld_pipe     <= {vld_pipe[STAGES-1:0], hit};
      pix_index    <= data_In[2:0];
      pix_valid    <= vld_pipe[STAGES] && (data_In[2:0] != 3'd0);
    end
  end

endmodule
